// File: rtl/tick_scheduler.sv
// Game time base: programmable base divider plus NUM_CH per-object channel dividers under a run/pause/stop FSM.
// Pulses are registered (1-cycle latency from the wrap decision); no backpressure, config writes land on the strobe edge.
module tick_scheduler #(
    parameter int          NUM_CH         = 4,
    parameter int          DIV_W          = 23,
    parameter int          PERIOD_W       = 8,
    parameter int unsigned DIV_DEFAULT    = 2500000,
    parameter int unsigned PERIOD_DEFAULT = 1
) (
    input  logic              i_Clk,
    input  logic              i_Rst,
    input  logic              i_Start,
    input  logic              i_Pause,
    input  logic              i_Stop,
    input  logic              i_Cfg_Wr,
    input  logic [2:0]        i_Cfg_Addr,
    input  logic [DIV_W-1:0]  i_Cfg_Data,
    output logic              o_Base_Tick,
    output logic [NUM_CH-1:0] o_Fire,
    output logic              o_Running,
    output logic [1:0]        o_State
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10
    } state_t;

    state_t state, state_nxt;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Stop beats Pause beats Start; Pause only means something in RUN.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!i_Stop && i_Start) state_nxt = S_RUN;
            S_RUN:    if (i_Stop) state_nxt = S_IDLE;
                      else if (i_Pause) state_nxt = S_PAUSED;
            S_PAUSED: if (i_Stop) state_nxt = S_IDLE;
                      else if (i_Start) state_nxt = S_RUN;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_Running = (state == S_RUN);
        o_State   = state;
    end

    // Counting only happens on edges that begin and end in RUN.
    logic run_go;
    logic clear;
    assign run_go = (state == S_RUN) && (state_nxt == S_RUN);
    assign clear  = (state_nxt == S_IDLE);

    logic [DIV_W-1:0] div_reg;
    logic [DIV_W-1:0] base_cnt;
    logic [DIV_W-1:0] div_new;
    logic [DIV_W-1:0] base_step;
    logic [DIV_W-1:0] base_nxt;
    logic             base_wrap;
    logic             div_wr;

    assign div_wr    = i_Cfg_Wr && (i_Cfg_Addr == 3'd7);
    assign div_new   = div_wr ? i_Cfg_Data : div_reg;
    assign base_wrap = run_go && (base_cnt == div_reg);

    // Tick decision uses the old divide; the clamp checks the next count against the new one.
    always_comb begin
        base_step = base_cnt;
        if (base_wrap)   base_step = '0;
        else if (run_go) base_step = base_cnt + 1'b1;
        base_nxt = base_step;
        if (clear || (base_step > div_new)) base_nxt = '0;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            div_reg     <= DIV_W'(DIV_DEFAULT);
            base_cnt    <= '0;
            o_Base_Tick <= 1'b0;
        end else begin
            div_reg     <= div_new;
            base_cnt    <= base_nxt;
            o_Base_Tick <= base_wrap;
        end
    end

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        logic [PERIOD_W-1:0] period_reg;
        logic [PERIOD_W-1:0] ch_cnt;
        logic [PERIOD_W-1:0] per_new;
        logic [PERIOD_W-1:0] cnt_step;
        logic [PERIOD_W-1:0] cnt_nxt;
        logic                per_wr;
        logic                ch_active;
        logic                fire_hit;
        logic                fire_q;

        assign per_wr    = i_Cfg_Wr && (i_Cfg_Addr == 3'(ch));
        assign per_new   = per_wr ? i_Cfg_Data[PERIOD_W-1:0] : period_reg;
        assign ch_active = base_wrap && (period_reg != '0);
        assign fire_hit  = ch_active && (ch_cnt == period_reg - PERIOD_W'(1));

        always_comb begin
            cnt_step = ch_cnt;
            if (fire_hit)       cnt_step = '0;
            else if (ch_active) cnt_step = ch_cnt + 1'b1;
            cnt_nxt = cnt_step;
            if (clear || (cnt_step >= per_new)) cnt_nxt = '0;
        end

        always_ff @(posedge i_Clk or posedge i_Rst) begin
            if (i_Rst) begin
                period_reg <= PERIOD_W'(PERIOD_DEFAULT);
                ch_cnt     <= '0;
                fire_q     <= 1'b0;
            end else begin
                period_reg <= per_new;
                ch_cnt     <= cnt_nxt;
                fire_q     <= fire_hit;
            end
        end

        assign o_Fire[ch] = fire_q;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: expected pulses and state probes are queued by the
// stimulus process and checked by an independent monitor on the falling edge.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 23;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, pause, stop;
    logic              cfg_wr;
    logic [2:0]        cfg_addr;
    logic [DIV_W-1:0]  cfg_data;
    logic              base_tick;
    logic [NUM_CH-1:0] fire;
    logic              running;
    logic [1:0]        state;

    tick_scheduler #(
        .NUM_CH        (NUM_CH),
        .DIV_W         (DIV_W),
        .PERIOD_W      (8),
        .DIV_DEFAULT   (9),
        .PERIOD_DEFAULT(1)
    ) dut (
        .i_Clk      (clk),
        .i_Rst      (rst),
        .i_Start    (start),
        .i_Pause    (pause),
        .i_Stop     (stop),
        .i_Cfg_Wr   (cfg_wr),
        .i_Cfg_Addr (cfg_addr),
        .i_Cfg_Data (cfg_data),
        .o_Base_Tick(base_tick),
        .o_Fire     (fire),
        .o_Running  (running),
        .o_State    (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] fire;
    } pulse_t;

    typedef struct {
        int         cyc;
        logic [1:0] st;
    } probe_t;

    pulse_t pulse_q[$];
    probe_t probe_q[$];
    bit     done = 1'b0;
    int     n_tests = 0;
    int     n_fail  = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic cfg(input logic [2:0] a, input int unsigned d);
        cfg_wr   = 1'b1;
        cfg_addr = a;
        cfg_data = DIV_W'(d);
        step(1);
        cfg_wr   = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic exp_pulse(input int c, input logic [3:0] f);
        pulse_t p;
        p.cyc  = c;
        p.fire = f;
        pulse_q.push_back(p);
    endtask

    task automatic exp_state(input int c, input logic [1:0] st);
        probe_t p;
        p.cyc = c;
        p.st  = st;
        probe_q.push_back(p);
    endtask

    // Stimulus
    initial begin : stim
        int s, s2, r, s3, t0;
        logic [3:0] f;
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
        cfg_wr = 1'b0; cfg_addr = '0; cfg_data = '0;
        step(3);
        exp_state(cyc, 2'b00);
        step(1);
        rst = 1'b0;

        // Test 1: div=3, ch0 per 1, ch1 per 3, ch2/ch3 off
        cfg(3'd7, 3); cfg(3'd0, 1); cfg(3'd1, 3); cfg(3'd2, 0); cfg(3'd3, 0);
        s = cyc + 1;
        do_start();
        exp_state(s, 2'b01);
        for (int k = 1; k <= 5; k++)
            exp_pulse(s + 4*k, {2'b00, (k % 3 == 0), 1'b1});

        // Test 3: Stop+Pause+Start together while ch1 is mid-count
        goto(s + 21);
        stop = 1'b1; pause = 1'b1; start = 1'b1;
        step(1);
        stop = 1'b0; pause = 1'b0; start = 1'b0;
        exp_state(s + 22, 2'b00);
        step(2);
        s2 = cyc + 1;
        do_start();
        exp_state(s2, 2'b01);
        exp_pulse(s2 + 4, 4'b0001);
        exp_pulse(s2 + 8, 4'b0001);

        // Test 2: pause after the 2nd tick, hold, then resume
        goto(s2 + 9);
        pause = 1'b1;
        step(1);
        pause = 1'b0;
        exp_state(s2 + 10, 2'b10);
        step(10);
        exp_state(s2 + 20, 2'b10);
        r = cyc + 1;
        do_start();
        exp_state(r, 2'b01);
        exp_pulse(r + 3,  4'b0011);
        exp_pulse(r + 7,  4'b0001);
        exp_pulse(r + 11, 4'b0001);
        exp_pulse(r + 15, 4'b0011);

        // Test 4: shrink divide to 1 while base_cnt is 2
        goto(r + 17);
        cfg(3'd7, 1);
        t0 = r + 20;
        for (int j = 0; j <= 22; j++) begin
            f = {1'b0, (j >= 12) && ((j - 12) % 2 == 1), (j % 3 == 2), 1'b1};
            exp_pulse(t0 + 2*j, f);
        end

        // Test 5: enable ch2 with period 2, then an unmapped write
        goto(t0 + 2*11);
        cfg(3'd2, 2);
        goto(t0 + 2*15);
        cfg(3'd5, 0);

        // Test 6: async reset right after a tick edge
        goto(t0 + 2*23);
        exp_state(cyc, 2'b00);
        #1 rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        exp_state(cyc, 2'b00);
        s3 = cyc + 1;
        do_start();
        exp_state(s3, 2'b01);
        exp_pulse(s3 + 10, 4'b1111);
        exp_pulse(s3 + 20, 4'b1111);
        goto(s3 + 22);
        done = 1'b1;
    end

    // Monitor / scoreboard
    initial begin : monitor
        pulse_t e;
        probe_t p;
        while (!done) begin
            @(negedge clk);
            while (probe_q.size() > 0 && probe_q[0].cyc < cyc) begin
                p = probe_q.pop_front();
                n_tests++; n_fail++;
                $display("FAIL state_probe_missed cyc=%0d expected_state=%b", p.cyc, p.st);
            end
            if (probe_q.size() > 0 && probe_q[0].cyc == cyc) begin
                p = probe_q.pop_front();
                n_tests++;
                if (state !== p.st || running !== (p.st == 2'b01)) begin
                    n_fail++;
                    $display("FAIL state cyc=%0d got state=%b running=%b expected state=%b", cyc, state, running, p.st);
                end
            end
            while (pulse_q.size() > 0 && pulse_q[0].cyc < cyc) begin
                e = pulse_q.pop_front();
                n_tests++; n_fail++;
                $display("FAIL pulse_missing cyc=%0d expected fire=%b", e.cyc, e.fire);
            end
            if (base_tick === 1'b1 || (|fire) === 1'b1) begin
                n_tests++;
                if (pulse_q.size() == 0 || pulse_q[0].cyc != cyc) begin
                    n_fail++;
                    $display("FAIL pulse_unexpected cyc=%0d got tick=%b fire=%b expected none", cyc, base_tick, fire);
                end else begin
                    e = pulse_q.pop_front();
                    if (base_tick !== 1'b1 || fire !== e.fire) begin
                        n_fail++;
                        $display("FAIL pulse cyc=%0d got tick=%b fire=%b expected tick=1 fire=%b", cyc, base_tick, fire, e.fire);
                    end
                end
            end
        end
        n_tests++;
        if (pulse_q.size() != 0 || probe_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover got pulses=%0d probes=%0d expected 0", pulse_q.size(), probe_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
